// File: rtl/quan_seq_ctrl.sv
// Sequencer for the uint8 re-quantize pipeline: per-channel params, sample streaming, byte packing.
// Latency: RD+LATCH per channel, QUAN_LAT pipeline cycles, packed word one edge after the byte capture.
// Backpressure: acc_ready is high only in RUN; there is no stall path from the output side.
module quan_seq_ctrl #(
  parameter int CH_MAX   = 64,
  parameter int QUAN_LAT = 5,
  parameter int PIX_W    = 16,
  localparam int CH_W    = $clog2(CH_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CH_W:0]    cfg_ch_num,
  input  logic [PIX_W-1:0] cfg_pix_num,
  input  logic             prm_we,
  input  logic [CH_W-1:0]  prm_addr,
  input  logic [31:0]      prm_m0,
  input  logic [7:0]       prm_index,
  input  logic [15:0]      prm_zw,
  input  logic [7:0]       prm_z3,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [31:0]      acc_data,
  input  logic [31:0]      acc_act_sum,
  output logic             q_valid_in,
  output logic [31:0]      q_serial32,
  output logic [31:0]      q_act_sum,
  output logic [31:0]      q_m0,
  output logic [7:0]       q_index,
  output logic [15:0]      q_zw,
  output logic [7:0]       q_z3,
  input  logic [7:0]       q_out,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic [CH_W-1:0]  out_ch,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_LATCH, ST_RUN, ST_DRAIN, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W:0]       ch_num_q, ch_num_d;
  logic [PIX_W-1:0]    pix_num_q, pix_num_d;
  logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [QUAN_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [2:0]          lane_q, lane_d;
  logic [63:0]         pack_q, pack_d;
  logic [31:0]         q_m0_q, q_m0_d;
  logic [7:0]          q_index_q, q_index_d;
  logic [15:0]         q_zw_q, q_zw_d;
  logic [7:0]          q_z3_q, q_z3_d;
  logic                out_valid_q, out_valid_d;
  logic [63:0]         out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;

  // Parameter table: {m0, index, zw, z3}, one entry per channel
  logic [63:0]         prm_mem [CH_MAX];
  logic [63:0]         prm_rd_dat;

  logic                hs;
  logic                pix_last;
  logic                ch_last;
  logic                byte_last;
  logic [63:0]         cap_word;

  assign acc_ready  = (state_q == ST_RUN);
  assign hs         = acc_valid & acc_ready;
  assign q_valid_in = hs;
  assign q_serial32 = acc_data;
  assign q_act_sum  = acc_act_sum;
  assign q_m0       = q_m0_q;
  assign q_index    = q_index_q;
  assign q_zw       = q_zw_q;
  assign q_z3       = q_z3_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_ch     = out_ch_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

  assign pix_last  = ((pix_cnt_q + PIX_W'(1)) == pix_num_q);
  assign byte_last = ((cap_cnt_q + PIX_W'(1)) == pix_num_q);
  assign ch_last   = (({1'b0, ch_idx_q} + (CH_W+1)'(1)) == ch_num_q);
  assign cap_word  = {56'd0, q_out} << {lane_q, 3'b000};

  // Table write only while idle so params never shift under a running layer; registered read in RD
  always_ff @(posedge clk) begin
    if (prm_we && state_q == ST_IDLE) begin
      prm_mem[prm_addr] <= {prm_m0, prm_index, prm_zw, prm_z3};
    end
    if (state_q == ST_RD) begin
      prm_rd_dat <= prm_mem[ch_idx_q];
    end
  end

  // Next-state, param hold, valid tracking and byte packing
  always_comb begin
    state_d     = state_q;
    ch_num_d    = ch_num_q;
    pix_num_d   = pix_num_q;
    ch_idx_d    = ch_idx_q;
    pix_cnt_d   = pix_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    vld_sr_d    = {vld_sr_q[QUAN_LAT-2:0], hs};
    lane_d      = lane_q;
    pack_d      = pack_q;
    q_m0_d      = q_m0_q;
    q_index_d   = q_index_q;
    q_zw_d      = q_zw_q;
    q_z3_d      = q_z3_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          ch_num_d  = cfg_ch_num;
          pix_num_d = cfg_pix_num;
          ch_idx_d  = '0;
          pix_cnt_d = '0;
          state_d   = (cfg_ch_num != '0 && cfg_pix_num != '0) ? ST_RD : ST_DONE;
        end
      end
      ST_RD:    state_d = ST_LATCH;
      ST_LATCH: begin
        q_m0_d    = prm_rd_dat[63:32];
        q_index_d = prm_rd_dat[31:24];
        q_zw_d    = prm_rd_dat[23:8];
        q_z3_d    = prm_rd_dat[7:0];
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (hs) begin
          if (pix_last) begin
            pix_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end
      // An empty shift reg means the channel's last byte was captured and its word is already out
      ST_DRAIN: begin
        if (vld_sr_q == '0) begin
          if (ch_last) begin
            state_d = ST_DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            state_d  = ST_RD;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (vld_sr_q[QUAN_LAT-1]) begin
      cap_cnt_d = byte_last ? '0 : cap_cnt_q + PIX_W'(1);
      if (lane_q == 3'd7 || byte_last) begin
        out_valid_d = 1'b1;
        out_data_d  = pack_q | cap_word;
        out_last_d  = byte_last;
        out_ch_d    = ch_idx_q;
        pack_d      = '0;
        lane_d      = '0;
      end else begin
        pack_d = pack_q | cap_word;
        lane_d = lane_q + 3'd1;
      end
    end
  end

  // State register; reset discards in-flight bytes and partial words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_num_q    <= '0;
      pix_num_q   <= '0;
      ch_idx_q    <= '0;
      pix_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      vld_sr_q    <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      q_m0_q      <= '0;
      q_index_q   <= '0;
      q_zw_q      <= '0;
      q_z3_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_num_q    <= ch_num_d;
      pix_num_q   <= pix_num_d;
      ch_idx_q    <= ch_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_sr_q    <= vld_sr_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      q_m0_q      <= q_m0_d;
      q_index_q   <= q_index_d;
      q_zw_q      <= q_zw_d;
      q_z3_q      <= q_z3_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

endmodule
